adder_share_arbiter: RTL and testbench

- Shares one 3-bit ripple adder datapath (`Top_Layer`: 3-bit A, 3-bit B, 4-bit SUM) among `NREQ` requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- Each accepted operand pair is latched, added, and returned as a registered 4-bit sum tagged with the requester ID.
- The block sits between client logic and the single shared adder instance, so that clients never drive the adder directly.

---
 rtl/adder_share_pkg.sv | 15 +
 rtl/Top_Layer.sv | 24 ++
 rtl/adder_share_arbiter_rr_pick.sv | 40 ++++
 rtl/adder_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_adder_share_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// adder_share_pkg
// Shared definitions for the adder-sharing arbiter: operand/sum widths and
// the FSM state encoding (2'd3 is unused and recovers to IDLE).
package adder_share_pkg;

  localparam int OPW  = 3;
  localparam int SUMW = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADD  = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/Top_Layer.sv
// Top_Layer
// 3-bit unsigned ripple-carry adder, carry-in tied to 0.
// Ports:
//   A   in  3  operand A
//   B   in  3  operand B
//   SUM out 4  A+B, bit 3 is the final carry
module Top_Layer (
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic [3:0] SUM
);

  logic [3:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign SUM[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign SUM[3] = carry[3];

endmodule

// File: rtl/adder_share_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Scans the request vector upward starting
// one past the previous winner, wrapping modulo N; the first set bit wins.
// Ports:
//   req  in  N   request vector
//   last in  IW  index of the previous winner
//   gnt  out N   one-hot grant (zero when no request)
//   idx  out IW  index of the winner
//   any  out 1   at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Priority scan from last+1 around the ring; first hit is latched via 'any'.
  always_comb begin
    int k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares a single Top_Layer 3-bit adder among NREQ requesters with a
// round-robin valid/ready handshake. A granted operand pair is latched,
// added in the next cycle and presented as a registered, ID-tagged sum.
// Ports:
//   clk        in  1        clock, rising edge
//   rst        in  1        synchronous active-high reset
//   req_valid  in  NREQ     per-requester valid
//   req_a      in  3*NREQ   operand A, requester i at [3i+2:3i]
//   req_b      in  3*NREQ   operand B, same packing
//   req_ready  out NREQ     one-hot grant (combinational)
//   rsp_valid  out 1        response holds a completed result
//   rsp_sum    out 4        registered sum
//   rsp_id     out IDW      owner of rsp_sum
//   rsp_ready  in  1        downstream accepts the response
//   busy       out 1        high in ADD or RESP
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [OPW*NREQ-1:0]  req_a,
  input  logic [OPW*NREQ-1:0]  req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [SUMW-1:0]      rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_ready,
  output logic                 busy
);

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [OPW-1:0]  op_a_q, op_a_d;
  logic [OPW-1:0]  op_b_q, op_b_d;
  logic [IDW-1:0]  op_id_q, op_id_d;
  logic [SUMW-1:0] rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic            can_grant;
  logic            handshake;
  logic [SUMW-1:0] add_sum;

  rr_pick #(.N(NREQ), .IW(IDW)) u_rr_pick (
    .req  (req_valid),
    .last (last_grant_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // The only adder instance; it only ever sees the latched operands.
  Top_Layer u_adder (
    .A   (op_a_q),
    .B   (op_b_q),
    .SUM (add_sum)
  );

  // A new grant is possible in IDLE, or in RESP in the cycle the response drains.
  always_comb begin
    can_grant = 1'b0;
    case (state_q)
      ST_IDLE: can_grant = 1'b1;
      ST_RESP: can_grant = rsp_ready;
      default: can_grant = 1'b0;
    endcase
    handshake = can_grant & pick_any;
    if (handshake) begin
      req_ready = pick_gnt;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state, operand latch and response register logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_id_d     = rsp_id_q;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        state_d   = ST_RESP;
        rsp_sum_d = add_sum;
        rsp_id_d  = op_id_q;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (handshake) begin
            state_d = ST_ADD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (handshake) begin
      op_a_d       = req_a[int'(pick_idx)*OPW +: OPW];
      op_b_d       = req_b[int'(pick_idx)*OPW +: OPW];
      op_id_d      = pick_idx;
      last_grant_d = pick_idx;
    end else begin
      op_id_d = op_id_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      rsp_sum_q    <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q == ST_ADD) || (state_q == ST_RESP);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard testbench for adder_share_arbiter. A transaction-level model
// predicts grants and pushes expected {id, sum} pairs; an independent monitor
// pops and compares whenever the DUT presents a response.
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [11:0]     req_a;
  logic [11:0]     req_b;
  logic [NREQ-1:0] req_ready;
  logic            rsp_valid;
  logic [3:0]      rsp_sum;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_ready;
  logic            busy;

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int id;
    int sum;
  } exp_t;

  exp_t sb_q[$];

  // Model: 0 = nothing in flight, 1 = operand latched, 2 = result on output.
  int m_stage = 0;
  int m_last  = NREQ - 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: round-robin choice by ring scan, occupancy-based grant rule.
  always @(negedge clk) begin : model
    int pick;
    bit can;
    logic [NREQ-1:0] exp_ready;
    exp_t e;
    if (rst) begin
      m_stage = 0;
      m_last  = NREQ - 1;
      sb_q.delete();
    end else begin
      pick = -1;
      for (int i = 1; i <= NREQ; i++) begin
        if (pick < 0 && req_valid[(m_last + i) % NREQ]) pick = (m_last + i) % NREQ;
      end
      can = (m_stage == 0) || (m_stage == 2 && rsp_ready);
      exp_ready = '0;
      if (can && pick >= 0) exp_ready[pick] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(m_stage != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_stage == 2));
      if (can && pick >= 0) begin
        e.id  = pick;
        e.sum = int'(req_a[3*pick +: 3]) + int'(req_b[3*pick +: 3]);
        sb_q.push_back(e);
        m_last  = pick;
        m_stage = 1;
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (m_stage == 2 && rsp_ready) begin
        m_stage = 0;
      end
    end
  end

  // Monitor: compare every presented response against the scoreboard head.
  always @(negedge clk) begin : monitor
    if (!rst && rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d sum %0d, expected no response", rsp_id, rsp_sum);
      end else begin
        chk("rsp_sum", 32'(rsp_sum), 32'(sb_q[0].sum));
        chk("rsp_id", 32'(rsp_id), 32'(sb_q[0].id));
        if (rsp_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [3:0] v, input logic [11:0] a, input logic [11:0] b,
                       input logic rr, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = rr;
      rst       = r;
    end
  endtask

  initial begin : stim
    logic [11:0] fa;
    logic [11:0] fb;
    logic [3:0]  rv;
    logic        rr;
    logic        rs;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    rst       = 1'b1;

    // Reset defaults.
    drive(4'b0000, 12'd0, 12'd0, 1'b0, 1'b1, 1);
    drive(4'b0000, 12'd0, 12'd0, 1'b1, 1'b0, 2);
    @(negedge clk);
    #1;
    chk("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);

    // Single request from requester 2: 5 + 6.
    drive(4'b0100, 12'd5 << 6, 12'd6 << 6, 1'b1, 1'b0, 1);
    drive(4'b0000, 12'd0, 12'd0, 1'b1, 1'b0, 4);

    // Round-robin fairness: all valid, a=i, b=7.
    fa = {3'd3, 3'd2, 3'd1, 3'd0};
    fb = {3'd7, 3'd7, 3'd7, 3'd7};
    drive(4'b1111, fa, fb, 1'b1, 1'b0, 10);
    drive(4'b0000, 12'd0, 12'd0, 1'b1, 1'b0, 4);

    // Backpressure: 7+7 held while requester 1 waits, then drained.
    drive(4'b0001, 12'd7, 12'd7, 1'b0, 1'b0, 1);
    drive(4'b0010, 12'd1 << 3, 12'd2 << 3, 1'b0, 1'b0, 7);
    drive(4'b0010, 12'd1 << 3, 12'd2 << 3, 1'b1, 1'b0, 1);
    drive(4'b0000, 12'd0, 12'd0, 1'b1, 1'b0, 4);

    // Reset while requester 0's operation is in ADD.
    drive(4'b0001, 12'd3, 12'd4, 1'b1, 1'b0, 1);
    drive(4'b0000, 12'd0, 12'd0, 1'b1, 1'b1, 1);
    drive(4'b0110, {3'd0, 3'd2, 3'd6, 3'd0}, {3'd0, 3'd5, 3'd1, 3'd0}, 1'b1, 1'b0, 1);
    drive(4'b0000, 12'd0, 12'd0, 1'b1, 1'b0, 4);

    // Sparse: only 3, then only 0 (wrap-around).
    drive(4'b1000, {3'd6, 9'd0}, {3'd5, 9'd0}, 1'b1, 1'b0, 1);
    drive(4'b0000, 12'd0, 12'd0, 1'b1, 1'b0, 3);
    drive(4'b0001, 12'd2, 12'd3, 1'b1, 1'b0, 1);
    drive(4'b0000, 12'd0, 12'd0, 1'b1, 1'b0, 4);

    // Randomized traffic with occasional backpressure and rare resets.
    for (int i = 0; i < 600; i++) begin
      rv = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 99) == 0);
      if (rs) rv = 4'b0000;
      drive(rv, 12'($urandom), 12'($urandom), rr, rs, 1);
    end
    drive(4'b0000, 12'd0, 12'd0, 1'b1, 1'b0, 6);

    @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
